reu_dma_engine: RTL and testbench
=================================

Name: reu_dma_engine

Overview:
- REU-style transfer engine; the initiator on the bus_manager DMA toggle handshake.
- Moves blocks between C64 memory, through bus_manager DMA cycles, and expansion RAM, through a req/ack RAM port.
- Supports four modes: stash, fetch, swap and verify.
- The register file loads the base, length and mode inputs and pulses start. Readback uses the live cur_* outputs.

Parameters:
- RAM_AW, 24: expansion RAM address width. REU addresses wrap modulo 2^RAM_AW.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a transfer; ignored while busy=1
- mode  in  2  00 stash C64->RAM, 01 fetch RAM->C64, 10 swap, 11 verify
- fix_c64  in  1  hold the C64 address constant
- fix_reu  in  1  hold the REU address constant
- c64_base  in  16  C64 start address, sampled at start
- reu_base  in  RAM_AW  RAM start address, sampled at start
- length  in  16  byte count, sampled at start; 0 means 65536
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse at completion
- end_of_block  out  1  sticky; set when the length is exhausted; cleared by start
- verify_error  out  1  sticky; set on a verify mismatch; cleared by start
- cur_c64  out  16  live C64 address
- cur_reu  out  RAM_AW  live REU address
- cur_len  out  16  live remaining length
- dma_a  out  16  DMA address to bus_manager
- dma_d  out  8  DMA write data
- dma_rw  out  1  1 = write to C64, 0 = read from C64
- dma_req  out  1  request toggle
- dma_ack  in  1  acknowledge toggle from bus_manager
- dma_q  in  8  C64 read data; valid when dma_ack equals dma_req
- ram_a  out  RAM_AW  RAM address
- ram_d  out  8  RAM write data
- ram_we  out  1  1 = write
- ram_req  out  1  level request
- ram_ack  in  1  one-cycle completion; ram_q valid in the same cycle
- ram_q  in  8  RAM read data

Behaviour:
- Reset values:
  - State is IDLE.
  - All outputs are 0.
  - cur_len is 1.
  - dma_req is 0.
- DMA handshake:
  - In IDLE, dma_req <= dma_ack every cycle, which absorbs any stale ack.
  - To issue a cycle, set dma_a, dma_d and dma_rw, then toggle dma_req in the same cycle. Hold all of them stable until dma_ack equals dma_req.
  - For reads, capture dma_q in the cycle the match is seen.
  - There is never more than one DMA cycle outstanding.
- RAM handshake:
  - Assert ram_req with ram_a, ram_d and ram_we stable. Hold them until ram_ack.
  - Deassert ram_req in the cycle after ram_ack.
  - For reads, capture ram_q on ram_ack.
  - DMA and RAM accesses never overlap.
- Start:
  - When start is seen in IDLE: load cur_c64 from c64_base, cur_reu from reu_base and cur_len from length.
  - Latch mode, fix_c64 and fix_reu.
  - Clear end_of_block and verify_error.
  - busy goes to 1 in the next cycle.
- States:
  - IDLE -> C64RD (stash, swap, verify) or RAMRD (fetch).
  - C64RD: DMA read at cur_c64 into byte A.
    - Stash -> RAMWR(A).
    - Swap or verify -> RAMRD.
  - RAMRD: RAM read at cur_reu into byte B.
    - Fetch -> C64WR(B).
    - Swap -> RAMWR(A).
    - Verify -> CMP.
  - RAMWR: RAM write.
    - Stash -> ADV.
    - Swap -> C64WR(B).
  - C64WR: DMA write of the byte at cur_c64 -> ADV.
  - CMP: if A != B, set verify_error and set a stop flag. Then -> ADV.
  - ADV: takes one cycle.
    - cur_c64 += 1 (16-bit wrap) unless fixed.
    - cur_reu += 1 (mod 2^RAM_AW) unless fixed.
    - If cur_len == 1: set end_of_block, keep cur_len at 1, go to DONE.
    - Else if stop is set: cur_len -= 1, go to DONE.
    - Else: cur_len -= 1, return to the mode's first state.
  - DONE: pulse done for one cycle, busy=0, go to IDLE.
- Length 0:
  - 0 decrements to 0xFFFF, so 65536 bytes are transferred.
- Verify mismatch on the last byte:
  - Both end_of_block and verify_error are set.
- Address wrap:
  - cur_c64 wraps 0xFFFF -> 0x0000.
  - cur_reu wraps all-ones -> 0.
- Reset mid-transfer:
  - The engine returns to IDLE immediately and abandons the transfer.
  - An outstanding DMA toggle is absorbed by IDLE tracking.
  - ram_req drops asynchronously.

Test Plan:
- Stash, mode=00, c64_base=0x1000, reu_base=0x000020, length=3, C64 bytes 11/22/33:
  - RAM[0x20..0x22] = 11/22/33.
  - Exactly 3 DMA reads and 3 RAM writes.
  - done pulses once; end_of_block=1; cur_c64=0x1003; cur_len=1.
- Fetch with fix_c64=1, c64_base=0xD020, length=2, RAM holds AA/BB:
  - Two DMA writes to 0xD020 with data AA then BB, dma_rw=1 on both.
  - cur_reu advances by 2.
- Swap, length=1, C64 holds 5A, RAM holds A5:
  - Afterwards C64 holds A5 and RAM holds 5A.
  - Access order: C64 read, RAM read, RAM write, C64 write.
- Verify, length=4, mismatch at byte 2 (0-based):
  - verify_error=1, end_of_block=0.
  - cur_c64 = base+3, cur_len=1.
  - No 4th access.
- Wrap with length=0, base 0xFFFF, RAM_AW=4, reu_base=0xF:
  - The second access targets C64 0x0000 and RAM 0x0.
  - Abort by reset_n after 5 bytes: busy=0 immediately.
  - A later start runs cleanly while dma_ack is stalled by one extra cycle.
- Handshake stress:
  - Delay dma_ack by 0 to 20 cycles and ram_ack by 0 to 5 cycles.
  - dma_a and dma_d stay stable while dma_req != dma_ack.
  - start pulsed while busy is ignored.

Source files
------------

// File: rtl/reu_dma_engine.sv
// REU-style block transfer engine.
// Moves bytes between C64 memory, reached through toggle-handshake DMA cycles,
// and expansion RAM, reached through a level req / pulse ack port.
// Modes: stash (C64->RAM), fetch (RAM->C64), swap, verify.
module reu_dma_engine #(
  parameter int RAM_AW = 24
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic              fix_c64,
  input  logic              fix_reu,
  input  logic [15:0]       c64_base,
  input  logic [RAM_AW-1:0] reu_base,
  input  logic [15:0]       length,
  output logic              busy,
  output logic              done,
  output logic              end_of_block,
  output logic              verify_error,
  output logic [15:0]       cur_c64,
  output logic [RAM_AW-1:0] cur_reu,
  output logic [15:0]       cur_len,
  output logic [15:0]       dma_a,
  output logic [7:0]        dma_d,
  output logic              dma_rw,
  output logic              dma_req,
  input  logic              dma_ack,
  input  logic [7:0]        dma_q,
  output logic [RAM_AW-1:0] ram_a,
  output logic [7:0]        ram_d,
  output logic              ram_we,
  output logic              ram_req,
  input  logic              ram_ack,
  input  logic [7:0]        ram_q
);

  localparam logic [1:0] MODE_STASH  = 2'b00;
  localparam logic [1:0] MODE_FETCH  = 2'b01;
  localparam logic [1:0] MODE_SWAP   = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_C64RD = 3'd1,
    S_RAMRD = 3'd2,
    S_RAMWR = 3'd3,
    S_C64WR = 3'd4,
    S_CMP   = 3'd5,
    S_ADV   = 3'd6,
    S_DONE  = 3'd7
  } state_t;

  state_t      state_r;
  logic [1:0]  mode_r;
  logic        fix_c64_r;
  logic        fix_reu_r;
  logic [7:0]  byte_a_r;
  logic [7:0]  byte_b_r;
  logic        dma_pend_r;
  logic        stop_r;

  // Fetch begins with the RAM side; every other mode begins by reading C64.
  function automatic state_t first_state(input logic [1:0] m);
    if (m == MODE_FETCH) begin
      return S_RAMRD;
    end else begin
      return S_C64RD;
    end
  endfunction

  // Transfer sequencer: one access at a time, all outputs registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= S_IDLE;
      mode_r       <= 2'b00;
      fix_c64_r    <= 1'b0;
      fix_reu_r    <= 1'b0;
      byte_a_r     <= 8'h00;
      byte_b_r     <= 8'h00;
      dma_pend_r   <= 1'b0;
      stop_r       <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      end_of_block <= 1'b0;
      verify_error <= 1'b0;
      cur_c64      <= 16'h0000;
      cur_reu      <= '0;
      cur_len      <= 16'd1;
      dma_a        <= 16'h0000;
      dma_d        <= 8'h00;
      dma_rw       <= 1'b0;
      dma_req      <= 1'b0;
      ram_a        <= '0;
      ram_d        <= 8'h00;
      ram_we       <= 1'b0;
      ram_req      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        S_IDLE: begin
          // Track the ack toggle so a late ack from an abandoned cycle is absorbed.
          dma_req <= dma_ack;
          if (start) begin
            cur_c64      <= c64_base;
            cur_reu      <= reu_base;
            cur_len      <= length;
            mode_r       <= mode;
            fix_c64_r    <= fix_c64;
            fix_reu_r    <= fix_reu;
            end_of_block <= 1'b0;
            verify_error <= 1'b0;
            stop_r       <= 1'b0;
            dma_pend_r   <= 1'b0;
            busy         <= 1'b1;
            state_r      <= first_state(mode);
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_C64RD: begin
          if (!dma_pend_r) begin
            dma_a      <= cur_c64;
            dma_rw     <= 1'b0;
            dma_req    <= ~dma_req;
            dma_pend_r <= 1'b1;
          end else if (dma_ack == dma_req) begin
            byte_a_r   <= dma_q;
            dma_pend_r <= 1'b0;
            state_r    <= (mode_r == MODE_STASH) ? S_RAMWR : S_RAMRD;
          end else begin
            state_r <= S_C64RD;
          end
        end
        S_RAMRD: begin
          if (!ram_req) begin
            ram_a   <= cur_reu;
            ram_we  <= 1'b0;
            ram_req <= 1'b1;
          end else if (ram_ack) begin
            byte_b_r <= ram_q;
            ram_req  <= 1'b0;
            case (mode_r)
              MODE_FETCH: state_r <= S_C64WR;
              MODE_SWAP:  state_r <= S_RAMWR;
              default:    state_r <= S_CMP;
            endcase
          end else begin
            state_r <= S_RAMRD;
          end
        end
        S_RAMWR: begin
          if (!ram_req) begin
            ram_a   <= cur_reu;
            ram_d   <= byte_a_r;
            ram_we  <= 1'b1;
            ram_req <= 1'b1;
          end else if (ram_ack) begin
            ram_req <= 1'b0;
            ram_we  <= 1'b0;
            state_r <= (mode_r == MODE_SWAP) ? S_C64WR : S_ADV;
          end else begin
            state_r <= S_RAMWR;
          end
        end
        S_C64WR: begin
          if (!dma_pend_r) begin
            dma_a      <= cur_c64;
            dma_d      <= byte_b_r;
            dma_rw     <= 1'b1;
            dma_req    <= ~dma_req;
            dma_pend_r <= 1'b1;
          end else if (dma_ack == dma_req) begin
            dma_pend_r <= 1'b0;
            state_r    <= S_ADV;
          end else begin
            state_r <= S_C64WR;
          end
        end
        S_CMP: begin
          if (byte_a_r != byte_b_r) begin
            verify_error <= 1'b1;
            stop_r       <= 1'b1;
          end else begin
            stop_r <= stop_r;
          end
          state_r <= S_ADV;
        end
        S_ADV: begin
          cur_c64 <= fix_c64_r ? cur_c64 : cur_c64 + 16'd1;
          cur_reu <= fix_reu_r ? cur_reu : cur_reu + RAM_AW'(1);
          if (cur_len == 16'd1) begin
            // Length stays at 1 so readback shows the exhausted block.
            end_of_block <= 1'b1;
            done         <= 1'b1;
            busy         <= 1'b0;
            state_r      <= S_DONE;
          end else if (stop_r) begin
            cur_len <= cur_len - 16'd1;
            done    <= 1'b1;
            busy    <= 1'b0;
            state_r <= S_DONE;
          end else begin
            // A length of 0 falls through to 0xFFFF here, giving 65536 bytes.
            cur_len <= cur_len - 16'd1;
            state_r <= first_state(mode_r);
          end
        end
        S_DONE: begin
          state_r <= S_IDLE;
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reu_dma_engine.sv
// Self-checking bench for reu_dma_engine: C64 bus and expansion RAM responders
// with random latency, and a byte-level transfer model that predicts the access
// log, final memories, counters and flags.
module tb_reu_dma_engine;

  localparam int AW  = 12;
  localparam int RSZ = 1 << AW;
  localparam logic [1:0] K_CRD = 2'd0;
  localparam logic [1:0] K_CWR = 2'd1;
  localparam logic [1:0] K_RRD = 2'd2;
  localparam logic [1:0] K_RWR = 2'd3;

  typedef struct packed {
    logic [1:0]  kind;
    logic [23:0] addr;
    logic [7:0]  data;
  } acc_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic          fix_c64 = 1'b0;
  logic          fix_reu = 1'b0;
  logic [15:0]   c64_base = 16'h0000;
  logic [AW-1:0] reu_base = '0;
  logic [15:0]   length = 16'h0000;
  logic          busy, done, end_of_block, verify_error;
  logic [15:0]   cur_c64, cur_len, dma_a;
  logic [AW-1:0] cur_reu, ram_a;
  logic [7:0]    dma_d, ram_d;
  logic          dma_rw, dma_req, ram_we, ram_req;
  logic          dma_ack = 1'b0;
  logic [7:0]    dma_q = 8'h00;
  logic          ram_ack = 1'b0;
  logic [7:0]    ram_q = 8'h00;

  reu_dma_engine #(.RAM_AW(AW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .mode(mode),
    .fix_c64(fix_c64), .fix_reu(fix_reu), .c64_base(c64_base),
    .reu_base(reu_base), .length(length), .busy(busy), .done(done),
    .end_of_block(end_of_block), .verify_error(verify_error),
    .cur_c64(cur_c64), .cur_reu(cur_reu), .cur_len(cur_len),
    .dma_a(dma_a), .dma_d(dma_d), .dma_rw(dma_rw), .dma_req(dma_req),
    .dma_ack(dma_ack), .dma_q(dma_q), .ram_a(ram_a), .ram_d(ram_d),
    .ram_we(ram_we), .ram_req(ram_req), .ram_ack(ram_ack), .ram_q(ram_q)
  );

  always #5 clk = ~clk;

  logic [7:0] c64_mem [65536];
  logic [7:0] ram_mem [RSZ];
  logic [7:0] exp_c64 [65536];
  logic [7:0] exp_ram [RSZ];
  acc_t act_q[$];
  acc_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int dma_min = 0;
  int dma_max = 20;
  int ram_max = 5;

  task automatic chk(input string tag, input logic [39:0] got, input logic [39:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic acc_t mk(input logic [1:0] k, input logic [23:0] a, input logic [7:0] d);
    return {k, a, d};
  endfunction

  // C64 bus responder: one toggle cycle at a time with random latency.
  logic          dpend = 1'b0;
  int            dcnt = 0;
  logic [15:0]   da;
  logic [7:0]    dd;
  logic          drw, dreq;
  always @(negedge clk) begin
    if (!dpend && reset_n && (dma_req != dma_ack)) begin
      da = dma_a; dd = dma_d; drw = dma_rw; dreq = dma_req;
      dcnt = int'($urandom_range(dma_max, dma_min));
      dpend = 1'b1;
    end else if (dpend && reset_n && busy && (dma_req == dreq)) begin
      chk("dma_stable", 40'({dma_a, dma_d, dma_rw}), 40'({da, dd, drw}));
    end
    if (dpend) begin
      if (dcnt == 0) begin
        if (drw) begin
          c64_mem[da] = dd;
          act_q.push_back(mk(K_CWR, 24'(da), dd));
        end else begin
          dma_q = c64_mem[da];
          act_q.push_back(mk(K_CRD, 24'(da), c64_mem[da]));
        end
        dma_ack = dreq;
        dpend = 1'b0;
      end else begin
        dcnt--;
      end
    end
  end

  // Expansion RAM responder: one-cycle ack after random latency.
  logic          rpend = 1'b0;
  int            rcnt = 0;
  logic [AW-1:0] ra;
  logic [7:0]    rd;
  logic          rwe;
  always @(negedge clk) begin
    if (reset_n) chk("no_overlap", 40'(ram_req && (dma_req != dma_ack)), 40'd0);
    if (ram_ack) begin
      ram_ack = 1'b0;
    end else if (!rpend && ram_req) begin
      ra = ram_a; rd = ram_d; rwe = ram_we;
      rcnt = int'($urandom_range(ram_max, 0));
      rpend = 1'b1;
    end else if (rpend && ram_req) begin
      chk("ram_stable", 40'({ram_a, ram_d, ram_we}), 40'({ra, rd, rwe}));
    end
    if (rpend && !ram_req) rpend = 1'b0;
    if (rpend) begin
      if (rcnt == 0) begin
        if (rwe) begin
          ram_mem[ra] = rd;
          act_q.push_back(mk(K_RWR, 24'(ra), rd));
        end else begin
          ram_q = ram_mem[ra];
          act_q.push_back(mk(K_RRD, 24'(ra), ram_mem[ra]));
        end
        ram_ack = 1'b1;
        rpend = 1'b0;
      end else begin
        rcnt--;
      end
    end
  end

  always @(negedge clk) if (done) done_cnt++;

  // Byte-level reference: what each transferred byte does to both memories.
  task automatic model(input logic [1:0] m, input logic fc, input logic fr,
                       input logic [15:0] cb, input logic [AW-1:0] rb,
                       input logic [15:0] len, input int limit,
                       output logic [15:0] e_c64, output logic [AW-1:0] e_reu,
                       output logic [15:0] e_len, output logic e_eob, output logic e_verr);
    int n;
    int p;
    logic [7:0] a, b;
    logic [15:0] ca;
    logic [AW-1:0] cr;
    n = (len == 16'd0) ? 65536 : int'(len);
    ca = cb; cr = rb; p = 0; e_eob = 1'b0; e_verr = 1'b0;
    for (int k = 0; k < 65536; k++) exp_c64[k] = c64_mem[k];
    for (int k = 0; k < RSZ; k++) exp_ram[k] = ram_mem[k];
    exp_q.delete();
    for (int i = 0; i < n && i < limit; i++) begin
      a = exp_c64[ca];
      b = exp_ram[cr];
      case (m)
        2'b00: begin
          exp_q.push_back(mk(K_CRD, 24'(ca), a));
          exp_q.push_back(mk(K_RWR, 24'(cr), a));
          exp_ram[cr] = a;
        end
        2'b01: begin
          exp_q.push_back(mk(K_RRD, 24'(cr), b));
          exp_q.push_back(mk(K_CWR, 24'(ca), b));
          exp_c64[ca] = b;
        end
        2'b10: begin
          exp_q.push_back(mk(K_CRD, 24'(ca), a));
          exp_q.push_back(mk(K_RRD, 24'(cr), b));
          exp_q.push_back(mk(K_RWR, 24'(cr), a));
          exp_q.push_back(mk(K_CWR, 24'(ca), b));
          exp_ram[cr] = a;
          exp_c64[ca] = b;
        end
        default: begin
          exp_q.push_back(mk(K_CRD, 24'(ca), a));
          exp_q.push_back(mk(K_RRD, 24'(cr), b));
          if (a != b) e_verr = 1'b1;
        end
      endcase
      if (!fc) ca = ca + 16'd1;
      if (!fr) cr = cr + AW'(1);
      p = i + 1;
      if (p == n) e_eob = 1'b1;
      if (e_verr || e_eob) break;
    end
    e_c64 = ca;
    e_reu = cr;
    e_len = e_eob ? 16'd1 : 16'(n - p);
  endtask

  task automatic run(input string tag, input logic [1:0] m, input logic fc, input logic fr,
                     input logic [15:0] cb, input logic [AW-1:0] rb, input logic [15:0] len,
                     input bit poke);
    logic [15:0] e_c64, e_len;
    logic [AW-1:0] e_reu;
    logic e_eob, e_verr;
    int diffs;
    model(m, fc, fr, cb, rb, len, 70000, e_c64, e_reu, e_len, e_eob, e_verr);
    act_q.delete();
    done_cnt = 0;
    @(negedge clk);
    mode = m; fix_c64 = fc; fix_reu = fr; c64_base = cb; reu_base = rb; length = len;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy"}, 40'(busy), 40'd1);
    if (poke) begin
      repeat (2) @(negedge clk);
      if (busy) begin
        mode = ~m; c64_base = ~cb; reu_base = ~rb; length = 16'd9;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    end
    for (int c = 0; c < 400 * int'(len) + 200 && done_cnt == 0; c++) @(negedge clk);
    chk({tag, "_done_seen"}, 40'(done_cnt != 0), 40'd1);
    repeat (2) @(negedge clk);
    chk({tag, "_done_once"}, 40'(done_cnt), 40'd1);
    chk({tag, "_idle"}, 40'(busy), 40'd0);
    chk({tag, "_eob"}, 40'(end_of_block), 40'(e_eob));
    chk({tag, "_verr"}, 40'(verify_error), 40'(e_verr));
    chk({tag, "_cur_c64"}, 40'(cur_c64), 40'(e_c64));
    chk({tag, "_cur_reu"}, 40'(cur_reu), 40'(e_reu));
    chk({tag, "_cur_len"}, 40'(cur_len), 40'(e_len));
    chk({tag, "_n_acc"}, 40'(act_q.size()), 40'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++)
      chk({tag, "_acc"}, 40'(act_q[i]), 40'(exp_q[i]));
    diffs = 0;
    for (int k = 0; k < 65536; k++) if (c64_mem[k] !== exp_c64[k]) diffs++;
    for (int k = 0; k < RSZ; k++) if (ram_mem[k] !== exp_ram[k]) diffs++;
    chk({tag, "_mem"}, 40'(diffs), 40'd0);
  endtask

  initial begin
    logic [15:0] w_c64, w_len;
    logic [AW-1:0] w_reu;
    logic w_eob, w_verr;
    logic [1:0] rm;
    logic [15:0] rlen, rcb;
    logic [AW-1:0] rrb;

    for (int k = 0; k < 65536; k++) c64_mem[k] = 8'($urandom);
    for (int k = 0; k < RSZ; k++) ram_mem[k] = 8'($urandom);

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_busy", 40'(busy), 40'd0);
    chk("rst_done", 40'(done), 40'd0);
    chk("rst_eob", 40'(end_of_block), 40'd0);
    chk("rst_verr", 40'(verify_error), 40'd0);
    chk("rst_cur_len", 40'(cur_len), 40'd1);
    chk("rst_cur_c64", 40'(cur_c64), 40'd0);
    chk("rst_dma_req", 40'(dma_req), 40'd0);
    chk("rst_ram_req", 40'(ram_req), 40'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Stash three bytes.
    c64_mem[16'h1000] = 8'h11; c64_mem[16'h1001] = 8'h22; c64_mem[16'h1002] = 8'h33;
    run("stash", 2'b00, 1'b0, 1'b0, 16'h1000, AW'(12'h020), 16'd3, 1'b1);
    chk("stash_ram20", 40'(ram_mem[12'h020]), 40'h11);
    chk("stash_ram22", 40'(ram_mem[12'h022]), 40'h33);
    chk("stash_cur_c64_abs", 40'(cur_c64), 40'h1003);

    // Fetch into a fixed C64 register address.
    ram_mem[12'h100] = 8'hAA; ram_mem[12'h101] = 8'hBB;
    run("fetch_fix", 2'b01, 1'b1, 1'b0, 16'hD020, AW'(12'h100), 16'd2, 1'b0);
    chk("fetch_c64_last", 40'(c64_mem[16'hD020]), 40'hBB);

    // Swap a single byte.
    c64_mem[16'h4000] = 8'h5A; ram_mem[12'h200] = 8'hA5;
    run("swap", 2'b10, 1'b0, 1'b0, 16'h4000, AW'(12'h200), 16'd1, 1'b0);
    chk("swap_c64", 40'(c64_mem[16'h4000]), 40'hA5);
    chk("swap_ram", 40'(ram_mem[12'h200]), 40'h5A);

    // Verify with a mismatch at byte 2 of 4.
    for (int i = 0; i < 4; i++) ram_mem[12'h300 + i] = c64_mem[16'h2000 + i];
    ram_mem[12'h302] = ~c64_mem[16'h2002];
    run("verify_mid", 2'b11, 1'b0, 1'b0, 16'h2000, AW'(12'h300), 16'd4, 1'b0);
    chk("verify_mid_verr", 40'(verify_error), 40'd1);
    chk("verify_mid_eob", 40'(end_of_block), 40'd0);

    // Verify with a mismatch on the last byte sets both flags.
    ram_mem[12'h400] = c64_mem[16'h2100];
    ram_mem[12'h401] = ~c64_mem[16'h2101];
    run("verify_last", 2'b11, 1'b0, 1'b0, 16'h2100, AW'(12'h400), 16'd2, 1'b0);

    // Length 0 with both addresses at the top, aborted by reset after 5 bytes.
    model(2'b00, 1'b0, 1'b0, 16'hFFFF, '1, 16'd0, 5, w_c64, w_reu, w_len, w_eob, w_verr);
    act_q.delete();
    @(negedge clk);
    mode = 2'b00; fix_c64 = 1'b0; fix_reu = 1'b0; c64_base = 16'hFFFF; reu_base = '1;
    length = 16'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 3000 && cur_len !== 16'hFFFB; c++) @(negedge clk);
    chk("wrap_len_after5", 40'(cur_len), 40'hFFFB);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_busy", 40'(busy), 40'd0);
    chk("abort_ram_req", 40'(ram_req), 40'd0);
    chk("abort_n_acc", 40'(act_q.size() >= 10), 40'd1);
    for (int i = 0; i < 10 && i < act_q.size(); i++)
      chk("wrap_acc", 40'(act_q[i]), 40'(exp_q[i]));
    if (act_q.size() >= 4) begin
      chk("wrap_c64_zero", 40'(act_q[2].addr), 40'd0);
      chk("wrap_ram_zero", 40'(act_q[3].addr), 40'd0);
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("abort_absorbed", 40'(dma_req), 40'(dma_ack));

    // Clean restart with the bus ack held back one extra cycle.
    dma_min = 1; dma_max = 1;
    run("restart_stall", 2'b00, 1'b0, 1'b0, 16'h3000, AW'(12'h500), 16'd4, 1'b0);
    dma_min = 0; dma_max = 20;

    // Randomized transfers under handshake stress.
    for (int it = 0; it < 12; it++) begin
      rm = 2'($urandom_range(3, 0));
      rlen = 16'($urandom_range(6, 1));
      rcb = 16'($urandom);
      rrb = AW'($urandom);
      if (rm == 2'b11 && $urandom_range(1, 0) == 1)
        for (int i = 0; i < 6; i++) ram_mem[AW'(rrb + AW'(i))] = c64_mem[16'(rcb + 16'(i))];
      run("rand", rm, ($urandom_range(3, 0) == 0), ($urandom_range(3, 0) == 0),
          rcb, rrb, rlen, (it % 2 == 0) && (rlen >= 16'd3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
